keypad_scan: RTL

Scans a 4x4 matrix keypad and turns each debounced key press into a 4-bit hex code plus a one-cycle strobe. It drives the column lines and reads the row lines from the board pins. It sits directly upstream of the hex-digit shift register: `value` feeds its `in` port and `trig` feeds its `trig` port, so each key press shifts one digit into the display.

---
 rtl/keypad_scan.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates a low column drive, debounces a single
// row hit on prescaled ticks, and emits a hex code with a one-cycle strobe.
module keypad_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] value,
  output logic       trig,
  output logic       key_down
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HOLD
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      row_meta, rs;
  logic [PW-1:0]   pre_cnt;
  logic            tick;
  logic [1:0]      ci, ci_nxt;
  logic [1:0]      ri, ri_nxt;
  logic [DW-1:0]   cnt, cnt_nxt;
  logic            accept;
  logic            row_hit;
  logic [1:0]      row_idx;
  logic [3:0]      press_pat;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Rows come straight from board pins, so they are double-flopped before use.
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      rs       <= 4'hF;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // A valid hit is exactly one low row; zero or several low rows are ignored.
  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // an unassigned path infers a latch.
  always_comb begin
    row_hit = 1'b1;
    row_idx = 2'd0;
    case (rs)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_hit = 1'b0;
    endcase
  end

  assign press_pat = ~(4'b0001 << ri);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_SCAN;
      ci    <= 2'd0;
      ri    <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ci    <= ci_nxt;
      ri    <= ri_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One counter serves both the press match count and the release count,
  // since the two are never live at the same time.
  always_comb begin
    state_nxt = state;
    ci_nxt    = ci;
    ri_nxt    = ri;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (row_hit) begin
            ri_nxt    = row_idx;
            cnt_nxt   = '0;
            state_nxt = ST_DEBOUNCE;
          end else begin
            ci_nxt = ci + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (rs == press_pat) begin
            if (cnt == DEB_LAST) begin
              accept    = 1'b1;
              cnt_nxt   = '0;
              state_nxt = ST_HOLD;
            end else begin
              cnt_nxt = cnt + DW'(1);
            end
          end else begin
            cnt_nxt   = '0;
            ci_nxt    = ci + 2'd1;
            state_nxt = ST_SCAN;
          end
        end
        ST_HOLD: begin
          if (rs == 4'hF) begin
            if (cnt == DEB_LAST) begin
              cnt_nxt   = '0;
              ci_nxt    = ci + 2'd1;
              state_nxt = ST_SCAN;
            end else begin
              cnt_nxt = cnt + DW'(1);
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = ST_SCAN;
        end
      endcase
    end
  end

  // value and trig move on the same edge so value is already valid while trig is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= 4'h0;
      trig  <= 1'b0;
    end else begin
      trig <= accept;
      if (accept) begin
        value <= key_code(ri, ci);
      end
    end
  end

  always_comb begin
    col      = ~(4'b0001 << ci);
    key_down = (state != ST_SCAN);
  end

endmodule
